// File: rtl/pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_pkg: load FSM states, timebase terminal count and 8-bit gamma helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } load_state_t;

  function automatic int cnt_max(input int res);
    return (1 << res) - 2;
  endfunction

  // Rounded cubic fit of a 2.2 gamma curve; exact at 0, 128 and 255.
  function automatic logic [7:0] gamma8(input logic [7:0] x);
    logic [31:0] num;
    num = 32'(x) * 32'(x) * (32'(x) + 32'd734);
    return 8'((num + 32'd126097) / 32'd252195);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_timebase: prescaler and shared period counter (0 .. 2^RES-2).
// Rev 1.0
// ----------------------------------------------------------------------------
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RES      = 8,
  parameter int PRESCALE = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           enable,
  output logic [RES-1:0] count,
  output logic           step,
  output logic           wrap,
  output logic           period_start
);

  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [RES-1:0] CNT_LAST   = RES'(cnt_max(RES));

  logic [PW-1:0] presc;

  // wrap flags the terminal count; the counter only wraps when step is also high.
  always_comb begin
    step = enable && (presc == PRESC_LAST);
    wrap = (count == CNT_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      count        <= '0;
      period_start <= 1'b0;
    end else if (!enable) begin
      presc        <= '0;
      count        <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= step ? '0 : presc + PW'(1);
      period_start <= step && wrap;
      if (step) begin
        count <= wrap ? '0 : count + RES'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_bank_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_bank_loader: double-buffered multi-channel PWM with load handshake.
// Optional gamma correction on transfer: define PWM_GAMMA_LUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module pwm_bank_loader
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int RES      = 8,
  parameter int PRESCALE = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [CHANNELS*RES-1:0] duty_bus,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic                    period_start,
  output logic [CHANNELS-1:0]     pwm
);

  load_state_t    state;
  load_state_t    state_next;
  logic           step;
  logic           wrap;
  logic           boundary;
  logic           capture;
  logic           transfer;
  logic [RES-1:0] count;
  logic [RES-1:0] shadow [CHANNELS];
  logic [RES-1:0] active [CHANNELS];

  pwm_timebase #(
    .RES      (RES),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .count        (count),
    .step         (step),
    .wrap         (wrap),
    .period_start (period_start)
  );

`ifdef PWM_GAMMA_LUT_EN
  if (RES != 8) begin : g_gamma_res_check
    $error("PWM_GAMMA_LUT_EN supports RES == 8 only");
  end

  function automatic logic [RES-1:0] to_active(input logic [RES-1:0] d);
    return RES'(gamma8(8'(d)));
  endfunction
`else
  function automatic logic [RES-1:0] to_active(input logic [RES-1:0] d);
    return d;
  endfunction
`endif

  // A disabled bank has no visible period, so any cycle is a safe swap point.
  assign boundary = !enable || (step && wrap);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_ack   = 1'b0;
    capture    = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        capture = load_req;
        if (boundary) begin
          transfer = 1'b1;
          load_ack = 1'b1;
          if (!load_req) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (capture) begin
          shadow[i] <= duty_bus[i*RES +: RES];
        end
        if (transfer) begin
          active[i] <= to_active(shadow[i]);
        end
        pwm[i] <= enable && (count < active[i]);
      end
    end
  end

endmodule
`default_nettype wire
